// File: rtl/ox_if.sv
// Pin bundle for the OX classifier board: keypad/buttons in, keypad rows,
// LEDs, 7-segment, LCD and classifier status out.
interface ox_if;
  logic [2:0]  in_from_keypad;
  logic        btn_a;
  logic        btn_b;
  logic        btn_c;
  logic        btn_d;
  logic        btn_submit;
  logic [3:0]  out_to_keypad;
  logic [7:0]  out_to_led;
  logic [7:0]  out_to_seg_data;
  logic [7:0]  out_to_seg_en;
  logic        lcd_e;
  logic        lcd_rw;
  logic        lcd_rs;
  logic [7:0]  lcd_data;
  logic [15:0] current_display;
  logic        nn_result_valid;
  logic        nn_y;
  logic [6:0]  nn_o_prob_pct;

  modport master (
    output in_from_keypad, btn_a, btn_b, btn_c, btn_d, btn_submit,
    input  out_to_keypad, out_to_led, out_to_seg_data, out_to_seg_en,
    input  lcd_e, lcd_rw, lcd_rs, lcd_data,
    input  current_display, nn_result_valid, nn_y, nn_o_prob_pct
  );

  modport slave (
    input  in_from_keypad, btn_a, btn_b, btn_c, btn_d, btn_submit,
    output out_to_keypad, out_to_led, out_to_seg_data, out_to_seg_en,
    output lcd_e, lcd_rw, lcd_rs, lcd_data,
    output current_display, nn_result_valid, nn_y, nn_o_prob_pct
  );
endinterface

// File: rtl/ox_top.sv
// OX board: 4x3 keypad scanner + 4 buttons -> debounced 4x4 cell toggles, X/O scorer,
// LED result and 7-segment percentage display (built only when OX_SEG7_EN is defined).

// Holds the 4x4 cell register and the saturating press counter.
module ox_input_mgr (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] press,
  output logic [15:0] combined_input_flags,
  output logic [4:0]  count_next_c,
  output logic        toggle_c
);
  logic [4:0]  input_count;
  logic [15:0] mask_c;
  logic [5:0]  sum_c;

  // Cell i lives in bit 15-i, so the press vector is bit-reversed into a toggle mask
  assign mask_c       = {<<{press}};
  assign sum_c        = 6'(input_count) + 6'($countones(press));
  assign count_next_c = (sum_c > 6'd16) ? 5'd16 : sum_c[4:0];
  assign toggle_c     = |press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      combined_input_flags <= '0;
      input_count          <= '0;
    end else begin
      combined_input_flags <= combined_input_flags ^ mask_c;
      input_count          <= count_next_c;
    end
  end
endmodule

module ox_top #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DB_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  ox_if.slave io
);
  localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [15:0] EDGE_MASK   = 16'h6996;
  localparam logic [15:0] CENTRE_MASK = 16'h0660;

  logic [SCW-1:0] scan_cnt_q;
  logic [1:0]     row_q;
  logic [3:0]     rows_q;
  logic           scan_tick_c;
  logic [2:0]     col_s1, col_s2;
  logic [3:0]     btn_s1, btn_s2;
  logic           sub_s1, sub_s2, sub_s3;
  logic [15:0]    samp_en_c, samp_v_c, press;
  logic [15:0]    flags;
  logic [4:0]     count_next_c;
  logic           toggle_c;

  // Row scanner: one low row per SCAN_DIV-clock step
  assign scan_tick_c = (scan_cnt_q == SCW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      row_q      <= 2'd0;
      rows_q     <= 4'b1110;
    end else if (scan_tick_c) begin
      scan_cnt_q <= '0;
      row_q      <= row_q + 2'd1;
      rows_q     <= {rows_q[2:0], rows_q[3]};
    end else begin
      scan_cnt_q <= scan_cnt_q + SCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1 <= 3'b111;
      col_s2 <= 3'b111;
      btn_s1 <= '0;
      btn_s2 <= '0;
      sub_s1 <= 1'b0;
      sub_s2 <= 1'b0;
      sub_s3 <= 1'b0;
    end else begin
      col_s1 <= io.in_from_keypad;
      col_s2 <= col_s1;
      btn_s1 <= {io.btn_d, io.btn_c, io.btn_b, io.btn_a};
      btn_s2 <= btn_s1;
      sub_s1 <= io.btn_submit;
      sub_s2 <= sub_s1;
      sub_s3 <= sub_s2;
    end
  end

  // Keys are sampled once per step on the active row; buttons every clock
  assign samp_en_c = {4'hF, scan_tick_c ? (12'h007 << (4'(row_q) * 4'd3)) : 12'h000};
  assign samp_v_c  = {btn_s2, {4{~col_s2}}};

  for (genvar g = 0; g < 16; g++) begin : g_db
    logic [DBW-1:0] cnt_q;
    logic           state_q;
    logic           press_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        state_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (samp_en_c[g]) begin
          if (samp_v_c[g] == state_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DBW'(DB_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= samp_v_c[g];
            press_q <= samp_v_c[g];
          end else begin
            cnt_q <= cnt_q + DBW'(1);
          end
        end
      end
    end
    assign press[g] = press_q;
  end

  ox_input_mgr INPUT_MGR (
    .clk                  (clk),
    .rst                  (rst),
    .press                (press),
    .combined_input_flags (flags),
    .count_next_c         (count_next_c),
    .toggle_c             (toggle_c)
  );

  // Classifier pipeline: capture -> score -> result; a cell toggle aborts it
  logic        sub_edge_c;
  logic [15:0] cap_q, cap_d;
  logic        stg1_q, stg1_d, stg2_q, stg2_d;
  logic [3:0]  bias_q, bias_d, bias_c;
  logic        valid_q, valid_d, y_q, y_d;
  logic [6:0]  pct_q, pct_d, pct_c;
  logic [7:0]  led_q, led_d;

  assign sub_edge_c = sub_s2 & ~sub_s3;
  // bias = score + 4, keeping the arithmetic unsigned (0..12)
  assign bias_c = 4'd4 + 4'($countones(cap_q & EDGE_MASK)) - 4'($countones(cap_q & CENTRE_MASK));
  assign pct_c  = 7'((9'(bias_q) * 9'd25) / 9'd3);

  always_comb begin
    stg1_d  = 1'b0;
    stg2_d  = 1'b0;
    cap_d   = cap_q;
    bias_d  = bias_q;
    valid_d = valid_q;
    y_d     = y_q;
    pct_d   = pct_q;
    if (toggle_c) begin
      valid_d = 1'b0;
    end else begin
      stg1_d = sub_edge_c;
      if (sub_edge_c) cap_d = flags;
      stg2_d = stg1_q;
      if (stg1_q) bias_d = bias_c;
      if (stg2_q) begin
        valid_d = 1'b1;
        y_d     = (bias_q >= 4'd7);
        pct_d   = pct_c;
      end
    end
    led_d = valid_d ? {y_d, pct_d} : {3'b000, count_next_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q   <= '0;
      stg1_q  <= 1'b0;
      stg2_q  <= 1'b0;
      bias_q  <= '0;
      valid_q <= 1'b0;
      y_q     <= 1'b0;
      pct_q   <= '0;
      led_q   <= '0;
    end else begin
      cap_q   <= cap_d;
      stg1_q  <= stg1_d;
      stg2_q  <= stg2_d;
      bias_q  <= bias_d;
      valid_q <= valid_d;
      y_q     <= y_d;
      pct_q   <= pct_d;
      led_q   <= led_d;
    end
  end

`ifdef OX_SEG7_EN
  logic [1:0] dig_q;
  logic [7:0] seg_data_q, seg_en_q, seg_c;
  logic [3:0] d_hun_c, d_ten_c, d_one_c;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  assign d_hun_c = 4'(pct_q / 7'd100);
  assign d_ten_c = 4'((pct_q % 7'd100) / 7'd10);
  assign d_one_c = 4'(pct_q % 7'd10);

  // Leading zeros are blanked; the units digit is always lit
  always_comb begin
    seg_c = 8'h00;
    case (dig_q)
      2'd0:    seg_c = seg7(d_one_c);
      2'd1:    seg_c = (d_hun_c != 4'd0 || d_ten_c != 4'd0) ? seg7(d_ten_c) : 8'h00;
      2'd2:    seg_c = (d_hun_c != 4'd0) ? seg7(d_hun_c) : 8'h00;
      default: seg_c = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q      <= 2'd0;
      seg_data_q <= 8'h00;
      seg_en_q   <= 8'hFF;
    end else begin
      if (scan_tick_c) dig_q <= (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
      if (valid_q) begin
        seg_data_q <= seg_c;
        seg_en_q   <= ~(8'h01 << dig_q);
      end else begin
        seg_data_q <= 8'h00;
        seg_en_q   <= 8'hFF;
      end
    end
  end

  assign io.out_to_seg_data = seg_data_q;
  assign io.out_to_seg_en   = seg_en_q;
`else
  assign io.out_to_seg_data = 8'h00;
  assign io.out_to_seg_en   = 8'hFF;
`endif

  assign io.out_to_keypad   = rows_q;
  assign io.out_to_led      = led_q;
  assign io.current_display = flags;
  assign io.nn_result_valid = valid_q;
  assign io.nn_y            = y_q;
  assign io.nn_o_prob_pct   = pct_q;
  assign io.lcd_e           = 1'b0;
  assign io.lcd_rw          = 1'b0;
  assign io.lcd_rs          = 1'b0;
  assign io.lcd_data        = 8'h00;
endmodule

// File: tb/tb_ox_top.sv
// Scoreboard bench for ox_top: keypad model, button presses, forced cell patterns,
// submit timing, reset abort and 7-segment digits (OX_SEG7_EN aware).
module tb_ox_top;
  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned DB_CYCLES = 2;

  typedef struct packed {
    logic       y;
    logic [6:0] pct;
    logic [7:0] led;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_on;
  logic [1:0] key_row, key_col;
  logic [15:0] exp_flags;
  int         exp_count;
  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       sb_q[$];

  ox_if io ();

  ox_top #(.SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  // Keypad matrix: the held key pulls its column low while its row is driven low
  assign io.in_from_keypad = (key_on && io.out_to_keypad == ~(4'b0001 << key_row)) ?
                             ~(3'b001 << key_col) : 3'b111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [15:0] f);
    logic [15:0] t;
    int   score;
    int   pct;
    exp_t e;
    t = f;
    score = 0;
    for (int c = 0; c < 16; c++) begin
      if (t[15]) begin
        case (c)
          1, 2, 4, 7, 8, 11, 13, 14: score++;
          5, 6, 9, 10:               score--;
          default:                   ;
        endcase
      end
      t = t << 1;
    end
    pct   = ((score + 4) * 25) / 3;
    e.y   = (score >= 3);
    e.pct = 7'(pct);
    e.led = {e.y, e.pct};
    return e;
  endfunction

  task automatic compare_result(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_valid"}, 32'(io.nn_result_valid), 32'd1);
      check({tag, "_y"},     32'(io.nn_y), 32'(e.y));
      check({tag, "_pct"},   32'(io.nn_o_prob_pct), 32'(e.pct));
      check({tag, "_led"},   32'(io.out_to_led), 32'(e.led));
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_kp"},     32'(io.out_to_keypad), 32'hE);
    check({p, "_flags"},  32'(io.current_display), 32'h0);
    check({p, "_count"},  32'(dut.INPUT_MGR.input_count), 32'h0);
    check({p, "_valid"},  32'(io.nn_result_valid), 32'h0);
    check({p, "_y"},      32'(io.nn_y), 32'h0);
    check({p, "_pct"},    32'(io.nn_o_prob_pct), 32'h0);
    check({p, "_led"},    32'(io.out_to_led), 32'h0);
    check({p, "_segd"},   32'(io.out_to_seg_data), 32'h0);
    check({p, "_sege"},   32'(io.out_to_seg_en), 32'hFF);
    check({p, "_lcd"},    32'({io.lcd_e, io.lcd_rw, io.lcd_rs, io.lcd_data}), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    exp_flags = '0;
    exp_count = 0;
  endtask

  task automatic press_key(input logic [1:0] r, input logic [1:0] c);
    key_row = r;
    key_col = c;
    key_on  = 1'b1;
    tick(120);
    key_on  = 1'b0;
    tick(120);
    exp_flags = exp_flags ^ (16'h8000 >> (r * 3 + c));
    exp_count = (exp_count < 16) ? exp_count + 1 : 16;
  endtask

  task automatic press_btn(input int b);
    {io.btn_d, io.btn_c, io.btn_b, io.btn_a} = 4'(1 << b);
    tick(10);
    {io.btn_d, io.btn_c, io.btn_b, io.btn_a} = 4'h0;
    tick(10);
    exp_flags = exp_flags ^ (16'h8000 >> (12 + b));
    exp_count = (exp_count < 16) ? exp_count + 1 : 16;
  endtask

  // Submit edge needs 2 sync clocks, then capture, score and result: valid after the 5th edge
  task automatic submit_and_compare(input logic [15:0] f, input string tag, input logic was_valid);
    sb_q.push_back(model(f));
    io.btn_submit = 1'b1;
    tick(4);
    check({tag, "_pre_valid"}, 32'(io.nn_result_valid), 32'(was_valid));
    tick(1);
    compare_result(tag);
    io.btn_submit = 1'b0;
    tick(3);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pulses;
    logic got;
    logic [7:0] seen[3];

    rst = 1'b1;
    key_on = 1'b0;
    key_row = 2'd0;
    key_col = 2'd0;
    io.btn_a = 1'b0;
    io.btn_b = 1'b0;
    io.btn_c = 1'b0;
    io.btn_d = 1'b0;
    io.btn_submit = 1'b0;
    exp_flags = '0;
    exp_count = 0;
    tick(3);
    check_reset("rst");
    rst = 1'b0;
    tick(2);

    // Key row1/col2 (cell 5) then btn_d (cell 15)
    press_key(2'd1, 2'd2);
    check("key5_count", 32'(dut.INPUT_MGR.input_count), 32'(exp_count));
    press_btn(3);
    check("cells_flags", 32'(io.current_display), 32'(exp_flags));
    check("cells_count", 32'(dut.INPUT_MGR.input_count), 32'(exp_count));
    check("cells_led",   32'(io.out_to_led), 32'({3'b000, 5'(exp_count)}));
    check("cells_valid", 32'(io.nn_result_valid), 32'd0);

    // Submit held for 100 clocks: a single computation
    sb_q.push_back(model(exp_flags));
    io.btn_submit = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (dut.stg1_q) pulses++;
      if (i == 4) check("hold_pre_valid", 32'(io.nn_result_valid), 32'd0);
      if (i == 5) compare_result("hold");
    end
    check("hold_one_compute", 32'(pulses), 32'd1);
    io.btn_submit = 1'b0;
    tick(5);

    // A toggle clears valid on the same edge the cell flips
    io.btn_a = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick(1);
      if (io.current_display !== exp_flags) got = 1'b1;
    end
    io.btn_a = 1'b0;
    exp_flags = exp_flags ^ 16'h0008;
    exp_count = exp_count + 1;
    check("toggle_seen",  32'(got), 32'd1);
    check("toggle_flags", 32'(io.current_display), 32'(exp_flags));
    check("toggle_valid", 32'(io.nn_result_valid), 32'd0);
    check("toggle_led",   32'(io.out_to_led), 32'({3'b000, 5'(exp_count)}));
    tick(10);

    // input_count saturates at 16
    for (int i = 0; i < 17; i++) press_btn(0);
    check("sat_count", 32'(dut.INPUT_MGR.input_count), 32'd16);
    check("sat_flags", 32'(io.current_display), 32'(exp_flags));
    check("sat_led",   32'(io.out_to_led), 32'h10);

    // Forced patterns, including recompute while already valid
    do_reset();
    force dut.INPUT_MGR.combined_input_flags = 16'h7D9F;
    submit_and_compare(16'h7D9F, "o_pat", 1'b0);
    force dut.INPUT_MGR.combined_input_flags = 16'h966D;
    sb_q.push_back(model(16'h966D));
    io.btn_submit = 1'b1;
    tick(4);
    check("recompute_hold_valid", 32'(io.nn_result_valid), 32'd1);
    check("recompute_hold_pct",   32'(io.nn_o_prob_pct), 32'd91);
    tick(1);
    compare_result("x_pat");
    io.btn_submit = 1'b0;
    tick(3);
    release dut.INPUT_MGR.combined_input_flags;

    // Reset one cycle after capture discards the result
    do_reset();
    force dut.INPUT_MGR.combined_input_flags = 16'h6996;
    io.btn_submit = 1'b1;
    tick(3);
    release dut.INPUT_MGR.combined_input_flags;
    io.btn_submit = 1'b0;
    rst = 1'b1;
    tick(1);
    check_reset("midrst");
    rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (io.nn_result_valid) got = 1'b1;
    end
    check("midrst_never_valid", 32'(got), 32'd0);
    check("midrst_led", 32'(io.out_to_led), 32'h0);

    // Score 8 -> 100 percent and its display
    do_reset();
    force dut.INPUT_MGR.combined_input_flags = 16'h6996;
    submit_and_compare(16'h6996, "full", 1'b0);
    seen[0] = 8'h00;
    seen[1] = 8'h00;
    seen[2] = 8'h00;
`ifdef OX_SEG7_EN
    for (int i = 0; i < 6 * SCAN_DIV; i++) begin
      tick(1);
      case (io.out_to_seg_en)
        8'hFE:   seen[0] = io.out_to_seg_data;
        8'hFD:   seen[1] = io.out_to_seg_data;
        8'hFB:   seen[2] = io.out_to_seg_data;
        default: check("seg_en_onehot", 32'(io.out_to_seg_en), 32'hFE);
      endcase
    end
    check("seg_units",    32'(seen[0]), 32'h3F);
    check("seg_tens",     32'(seen[1]), 32'h3F);
    check("seg_hundreds", 32'(seen[2]), 32'h06);
`else
    for (int i = 0; i < 3; i++) begin
      tick(SCAN_DIV);
      check("seg_off_en",   32'(io.out_to_seg_en), 32'hFF);
      check("seg_off_data", 32'(io.out_to_seg_data | seen[0]), 32'h00);
    end
`endif
    release dut.INPUT_MGR.combined_input_flags;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
